// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_master_arbiter
// Description : Round-robin AHB arbiter for three masters (DMA, CPU, debug)
//               with fixed-length burst protection and locked-transfer hold.
//               Drives the one-hot grant, the address/data-phase master
//               selects for the decode/mux stage, and HMASTER/HMASTLOCK.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_master_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 1
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [1:0]             hmsel,
    output logic [1:0]             hmsel_data,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] c_st_arb       = 2'd0;
    localparam logic [1:0] c_st_burst     = 2'd1;
    localparam logic [1:0] c_st_locked    = 2'd2;
    localparam logic [1:0] c_st_lock_tail = 2'd3;

    localparam logic [1:0] c_trans_idle   = 2'b00;
    localparam logic [1:0] c_trans_nonseq = 2'b10;
    localparam logic [1:0] c_trans_seq    = 2'b11;

    localparam logic [1:0]             c_default_idx = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] c_reset_grant =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;
    logic [1:0]             r_ptr;
    logic [1:0]             w_ptr_next;
    logic [1:0]             r_gidx;
    logic [1:0]             w_gidx_next;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_next;
    logic [1:0]             r_hmsel;
    logic [1:0]             r_hmsel_data;
    logic                   r_hmastlock;

    logic [3:0]             w_burst_len;
    logic                   w_load;
    logic                   w_err_clear;
    logic                   w_owner_lock;
    logic [1:0]             w_rr_idx;
    logic                   w_rr_found;
    logic [1:0]             w_rr_probe;

    // Beats-minus-one for fixed-length bursts; SINGLE and INCR give zero.
    always_comb begin
        w_burst_len = 4'd0;
        case (HBURST)
            3'b010, 3'b011: w_burst_len = 4'd3;
            3'b100, 3'b101: w_burst_len = 4'd7;
            3'b110, 3'b111: w_burst_len = 4'd15;
            default:        w_burst_len = 4'd0;
        endcase
    end

    assign w_load       = HREADY && (HTRANS == c_trans_nonseq) && (w_burst_len != 4'd0);
    assign w_err_clear  = !HREADY && (HRESP != 2'b00);
    assign w_owner_lock = HBUSREQ[r_gidx] && HLOCK[r_gidx];

    // Burst beat counter: error and IDLE both abandon whatever burst is in flight.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_err_clear) begin
            w_cnt_next = 4'd0;
        end else if (HREADY) begin
            case (HTRANS)
                c_trans_nonseq: if (w_burst_len != 4'd0) w_cnt_next = w_burst_len;
                c_trans_seq:    if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
                c_trans_idle:   w_cnt_next = 4'd0;
                default:        w_cnt_next = r_cnt;
            endcase
        end
    end

    // First requester after the pointer in circular order; scanning from the
    // farthest offset down lets the nearest requester win.
    always_comb begin
        w_rr_idx   = c_default_idx;
        w_rr_found = 1'b0;
        w_rr_probe = 2'd0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_rr_probe = 2'((int'(r_ptr) + k) % NUM_MASTERS);
            if (HBUSREQ[w_rr_probe]) begin
                w_rr_idx   = w_rr_probe;
                w_rr_found = 1'b1;
            end
        end
    end

    // Arbitration state machine: lock beats burst, both freeze the grant.
    always_comb begin
        w_state_next = r_state;
        w_gidx_next  = r_gidx;
        w_ptr_next   = r_ptr;
        case (r_state)
            c_st_arb: begin
                if (w_owner_lock) begin
                    w_state_next = c_st_locked;
                end else if (w_load) begin
                    w_state_next = c_st_burst;
                end else begin
                    w_gidx_next = w_rr_idx;
                    if (w_rr_found) w_ptr_next = w_rr_idx;
                end
            end
            c_st_burst:     if (w_cnt_next == 4'd0) w_state_next = c_st_arb;
            c_st_locked:    if (!HLOCK[r_gidx]) w_state_next = c_st_lock_tail;
            c_st_lock_tail: w_state_next = c_st_arb;
            default:        w_state_next = c_st_arb;
        endcase
    end

    // One-hot decode of the next grantee.
    always_comb begin
        w_grant_next              = '0;
        w_grant_next[w_gidx_next] = 1'b1;
    end

    // State registers; ownership qualifiers only advance on HREADY edges.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= c_st_arb;
            r_cnt        <= 4'd0;
            r_ptr        <= c_default_idx;
            r_gidx       <= c_default_idx;
            r_grant      <= c_reset_grant;
            r_hmsel      <= c_default_idx;
            r_hmsel_data <= c_default_idx;
            r_hmastlock  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            r_gidx  <= w_gidx_next;
            r_grant <= w_grant_next;
            if (HREADY) begin
                r_hmsel      <= r_gidx;
                r_hmsel_data <= r_hmsel;
                r_hmastlock  <= HLOCK[r_gidx];
            end
        end
    end

    assign HGRANT     = r_grant;
    assign hmsel      = r_hmsel;
    assign hmsel_data = r_hmsel_data;
    assign HMASTER    = {2'b00, r_hmsel};
    assign HMASTLOCK  = r_hmastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_master_arbiter
// Description : Self-checking bench for ahb_master_arbiter: directed scenarios
//               followed by random traffic, all compared against a
//               behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_master_arbiter;

    localparam int c_def = 1;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [2:0] HBUSREQ = '0;
    logic [2:0] HLOCK = '0;
    logic [1:0] HTRANS = '0;
    logic [2:0] HBURST = '0;
    logic       HREADY = 1'b1;
    logic [1:0] HRESP = '0;
    logic [2:0] HGRANT;
    logic [1:0] hmsel;
    logic [1:0] hmsel_data;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_grant, m_ptr, m_cnt, m_hmsel, m_hmsel_data, m_lock_q;
    bit m_burst_hold, m_locked, m_tail;

    ahb_master_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(c_def)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HBUSREQ    (HBUSREQ),
        .HLOCK      (HLOCK),
        .HTRANS     (HTRANS),
        .HBURST     (HBURST),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HGRANT     (HGRANT),
        .hmsel      (hmsel),
        .hmsel_data (hmsel_data),
        .HMASTER    (HMASTER),
        .HMASTLOCK  (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant = c_def; m_ptr = 1; m_cnt = 0;
        m_hmsel = c_def; m_hmsel_data = c_def; m_lock_q = 0;
        m_burst_hold = 0; m_locked = 0; m_tail = 0;
    endtask

    // One clock edge of the arbitration rules, evaluated on the sampled inputs.
    task automatic model_edge();
        int beats, ncnt, old_grant, g;
        bit load, err;
        beats = (HBURST >= 3'd2) ? (4 << ((int'(HBURST) - 2) / 2)) : 0;
        err   = !HREADY && (HRESP != 2'b00);
        load  = HREADY && (HTRANS == 2'b10) && (beats > 0);
        ncnt  = m_cnt;
        if (err) ncnt = 0;
        else if (HREADY) begin
            if (HTRANS == 2'b10 && beats > 0)      ncnt = beats - 1;
            else if (HTRANS == 2'b11 && m_cnt > 0) ncnt = m_cnt - 1;
            else if (HTRANS == 2'b00)              ncnt = 0;
        end
        old_grant = m_grant;
        if (m_tail) m_tail = 0;
        else if (m_locked) begin
            if (!HLOCK[m_grant]) begin m_locked = 0; m_tail = 1; end
        end else if (m_burst_hold) begin
            if (ncnt == 0) m_burst_hold = 0;
        end else if (HBUSREQ[m_grant] && HLOCK[m_grant]) m_locked = 1;
        else if (load) m_burst_hold = 1;
        else if (HBUSREQ == 3'b000) m_grant = c_def;
        else begin
            for (int k = 1; k <= 3; k++) begin
                g = (m_ptr + k) % 3;
                if (HBUSREQ[g]) begin m_grant = g; m_ptr = g; break; end
            end
        end
        m_cnt = ncnt;
        if (HREADY) begin
            m_hmsel_data = m_hmsel;
            m_hmsel      = old_grant;
            m_lock_q     = int'(HLOCK[old_grant]);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input logic rst, input logic [2:0] req, input logic [2:0] lk,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [1:0] rsp);
        @(negedge HCLK);
        HRESET = rst; HBUSREQ = req; HLOCK = lk; HTRANS = tr;
        HBURST = bu; HREADY = rdy; HRESP = rsp;
        @(posedge HCLK);
        if (rst) model_reset(); else model_edge();
        #1;
        check_value("HGRANT",     8'(HGRANT),     8'(1 << m_grant));
        check_value("hmsel",      8'(hmsel),      8'(m_hmsel));
        check_value("hmsel_data", 8'(hmsel_data), 8'(m_hmsel_data));
        check_value("HMASTER",    8'(HMASTER),    8'(m_hmsel));
        check_value("HMASTLOCK",  8'(HMASTLOCK),  8'(m_lock_q));
    endtask

    initial begin
        int exp_g[6];
        int exp_s[6];
        int saved_sel, saved_data;
        logic [2:0] r_req, r_lk;
        logic [1:0] r_tr, r_rsp;
        logic [2:0] r_bu;
        logic       r_rdy, r_rst;
        int         t;

        model_reset();

        // Reset held with everyone requesting
        for (int i = 0; i < 2; i++) begin
            step(1, 3'b111, 3'b000, 2'b00, 3'b000, 1, 2'b00);
            check_value("rst_grant", 8'(HGRANT), 8'h02);
            check_value("rst_hmsel", 8'(hmsel),  8'h01);
            check_value("rst_hmaster", 8'(HMASTER), 8'h01);
        end
        step(0, 3'b111, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        check_value("post_rst_grant", 8'(HGRANT), 8'h04);

        // Round-robin with SINGLE transfers
        exp_g = '{0, 1, 2, 0, 1, 2};
        exp_s = '{2, 0, 1, 2, 0, 1};
        for (int i = 0; i < 6; i++) begin
            step(0, 3'b111, 3'b000, 2'b10, 3'b000, 1, 2'b00);
            check_value("rr_grant", 8'(HGRANT), 8'(1 << exp_g[i]));
            check_value("rr_hmsel", 8'(hmsel),  8'(exp_s[i]));
        end

        // INCR4 with one BUSY, M2 waiting
        step(0, 3'b001, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        check_value("incr4_own", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b10, 3'b011, 1, 2'b00);
        check_value("incr4_ns", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b11, 3'b011, 1, 2'b00);
        check_value("incr4_s1", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b01, 3'b011, 1, 2'b00);
        check_value("incr4_busy", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b11, 3'b011, 1, 2'b00);
        check_value("incr4_s2", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b11, 3'b011, 1, 2'b00);
        check_value("incr4_s3", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        check_value("incr4_release", 8'(HGRANT), 8'h04);

        // WRAP8 terminated early by IDLE
        step(0, 3'b001, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        step(0, 3'b101, 3'b000, 2'b10, 3'b100, 1, 2'b00);
        step(0, 3'b101, 3'b000, 2'b11, 3'b100, 1, 2'b00);
        step(0, 3'b101, 3'b000, 2'b11, 3'b100, 1, 2'b00);
        step(0, 3'b101, 3'b000, 2'b00, 3'b100, 1, 2'b00);
        check_value("wrap8_idle_hold", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        check_value("wrap8_idle_release", 8'(HGRANT), 8'h04);

        // WRAP8 terminated by an error response
        step(0, 3'b001, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        step(0, 3'b101, 3'b000, 2'b10, 3'b100, 1, 2'b00);
        step(0, 3'b101, 3'b000, 2'b11, 3'b100, 1, 2'b00);
        step(0, 3'b101, 3'b000, 2'b11, 3'b100, 0, 2'b01);
        check_value("wrap8_err_hold", 8'(HGRANT), 8'h01);
        step(0, 3'b101, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        check_value("wrap8_err_release", 8'(HGRANT), 8'h04);

        // Locked sequence by M2
        for (int i = 0; i < 5; i++) begin
            step(0, 3'b111, 3'b100, 2'b10, 3'b000, 1, 2'b00);
            check_value("lock_grant", 8'(HGRANT), 8'h04);
            check_value("lock_mastlock", 8'(HMASTLOCK), 8'h01);
        end
        step(0, 3'b111, 3'b000, 2'b10, 3'b000, 1, 2'b00);
        check_value("lock_tail_grant", 8'(HGRANT), 8'h04);
        step(0, 3'b111, 3'b000, 2'b10, 3'b000, 1, 2'b00);
        check_value("lock_exit_grant", 8'(HGRANT), 8'h04);
        step(0, 3'b111, 3'b000, 2'b10, 3'b000, 1, 2'b00);
        check_value("lock_resume", 8'(HGRANT), 8'h01);

        // Wait states during a grant change
        saved_sel  = m_hmsel;
        saved_data = m_hmsel_data;
        for (int i = 0; i < 3; i++) begin
            step(0, 3'b010, 3'b000, 2'b00, 3'b000, 0, 2'b00);
            check_value("wait_hmsel", 8'(hmsel), 8'(saved_sel));
            check_value("wait_hmsel_data", 8'(hmsel_data), 8'(saved_data));
        end
        check_value("wait_grant", 8'(HGRANT), 8'h02);
        step(0, 3'b010, 3'b000, 2'b00, 3'b000, 1, 2'b00);
        check_value("wait_release_hmsel", 8'(hmsel), 8'h01);
        check_value("wait_release_data", 8'(hmsel_data), 8'(saved_sel));

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_req = 3'($urandom_range(0, 7));
            r_lk  = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 5) == 0)};
            t = $urandom_range(0, 9);
            r_tr  = (t == 0) ? 2'b00 : (t == 1) ? 2'b01 : (t < 4) ? 2'b10 : 2'b11;
            r_bu  = 3'($urandom_range(0, 7));
            r_rdy = ($urandom_range(0, 4) != 0);
            r_rsp = ($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00;
            step(r_rst, r_req, r_lk, r_tr, r_bu, r_rdy, r_rsp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
